ddr_axi_resp_model: RTL

- Synthesizable responder for the DDR3 controller user-side AXI-like port. It answers write-address, write-data, read-address and read-data traffic from on-chip block RAM.
- Stands in for the DDR3 controller so that traffic generators and Ethernet datapath logic can be brought up and regressed without a DDR PHY or memory device.
- Reproduces the controller's init-done gating, its pull-style write data (slave-driven wready, no wvalid) and its unthrottled read return (no rready).

---
 rtl/ddr_axi_resp_model.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ddr_axi_resp_model.sv
// ddr_axi_resp_model: block-RAM responder that stands in for the DDR3
// controller user port. It gates traffic on an init-done delay, pulls write
// data with a slave-driven wready, and returns read bursts without backpressure.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   ddr_init_done               memory ready (rises INIT_CYCLES after reset)
//   axi_aw*                     write address channel (awready is combinational)
//   axi_wdata/wstrb             write beat payload, sampled while axi_wready=1
//   axi_wready/wusero_id/last   write data pull, burst ID and final-beat flag
//   axi_ar*                     read address channel (arready is combinational)
//   axi_rdata/rid/rlast/rvalid  read return, zero whenever rvalid=0
module ddr_axi_resp_model #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned INIT_CYCLES = 200,
    parameter int unsigned RD_LAT      = 4
) (
    input  logic         clk,
    input  logic         resetn,
    output logic         ddr_init_done,
    input  logic [27:0]  axi_awaddr,
    input  logic         axi_awuser_ap,
    input  logic [3:0]   axi_awuser_id,
    input  logic [3:0]   axi_awlen,
    input  logic         axi_awvalid,
    output logic         axi_awready,
    input  logic [255:0] axi_wdata,
    input  logic [31:0]  axi_wstrb,
    output logic         axi_wready,
    output logic [3:0]   axi_wusero_id,
    output logic         axi_wusero_last,
    input  logic [27:0]  axi_araddr,
    input  logic         axi_aruser_ap,
    input  logic [3:0]   axi_aruser_id,
    input  logic [3:0]   axi_arlen,
    input  logic         axi_arvalid,
    output logic         axi_arready,
    output logic [255:0] axi_rdata,
    output logic [3:0]   axi_rid,
    output logic         axi_rlast,
    output logic         axi_rvalid
);

    localparam int unsigned DATA_W = 256;
    localparam int unsigned STRB_W = 32;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned IDX_W  = DEPTH_LOG2;
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int unsigned LAT_W  = $clog2(RD_LAT) + 1;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WR_DATA, S_RD_WAIT, S_RD_DATA
    } state_e;

    state_e              state_q, state_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic                init_done_q, init_done_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                wready_q, wready_d;
    logic                wlast_q, wlast_d;
    logic [ID_W-1:0]     wid_q, wid_d;
    logic                rvalid_q, rvalid_d;
    logic                rlast_q, rlast_d;
    logic [ID_W-1:0]     rid_q, rid_d;
    logic [DATA_W-1:0]   rdata_q;
    logic                rd_en, rd_clr;
    logic                aw_hs, ar_hs, init_last;
    logic [DATA_W-1:0]   mem [DEPTH];

    // Auto-precharge hints and the address bits outside the word index are don't-care.
    logic unused_inputs;
    assign unused_inputs = ^{axi_awuser_ap, axi_aruser_ap, axi_awaddr, axi_araddr};

    assign init_last = (init_cnt_q == INIT_W'(INIT_CYCLES - 1));

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_INIT;
        else         state_q <= state_d;
    end

    // Next-state logic; one transaction in flight at a time.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:    if (init_last) state_d = S_IDLE;
            S_IDLE: begin
                if (aw_hs)      state_d = S_WR_DATA;
                else if (ar_hs) state_d = S_RD_WAIT;
            end
            S_WR_DATA: if (beat_q == '0) state_d = S_IDLE;
            S_RD_WAIT: if (lat_q == '0)  state_d = S_RD_DATA;
            S_RD_DATA: if (beat_q == '0) state_d = S_IDLE;
            default:   state_d = S_INIT;
        endcase
    end

    // Address-channel readies; a pending write blocks the read in the same cycle.
    always_comb begin
        axi_awready = init_done_q && (state_q == S_IDLE);
        axi_arready = init_done_q && (state_q == S_IDLE) && !axi_awvalid;
        aw_hs       = axi_awvalid && axi_awready;
        ar_hs       = axi_arvalid && axi_arready;
    end

    // Datapath next-state: beat_q counts beats remaining after the current one.
    always_comb begin
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        idx_d       = idx_q;
        beat_d      = beat_q;
        id_d        = id_q;
        lat_d       = lat_q;
        wready_d    = wready_q;
        wlast_d     = wlast_q;
        wid_d       = wid_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        rid_d       = rid_q;
        rd_en       = 1'b0;
        rd_clr      = 1'b0;
        case (state_q)
            S_INIT: begin
                init_cnt_d = init_cnt_q + INIT_W'(1);
                if (init_last) init_done_d = 1'b1;
            end
            S_IDLE: begin
                if (aw_hs) begin
                    idx_d    = axi_awaddr[DEPTH_LOG2+2:3];
                    beat_d   = axi_awlen;
                    wready_d = 1'b1;
                    wlast_d  = (axi_awlen == '0);
                    wid_d    = axi_awuser_id;
                end else if (ar_hs) begin
                    idx_d  = axi_araddr[DEPTH_LOG2+2:3];
                    beat_d = axi_arlen;
                    id_d   = axi_aruser_id;
                    lat_d  = LAT_W'(RD_LAT - 2);
                end
            end
            S_WR_DATA: begin
                idx_d = idx_q + IDX_W'(1);
                if (beat_q == '0) begin
                    wready_d = 1'b0;
                    wlast_d  = 1'b0;
                    wid_d    = '0;
                end else begin
                    beat_d  = beat_q - LEN_W'(1);
                    wlast_d = (beat_q == LEN_W'(1));
                end
            end
            S_RD_WAIT: begin
                if (lat_q == '0) begin
                    rd_en    = 1'b1;
                    idx_d    = idx_q + IDX_W'(1);
                    rvalid_d = 1'b1;
                    rid_d    = id_q;
                    rlast_d  = (beat_q == '0);
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_RD_DATA: begin
                if (beat_q == '0) begin
                    rd_clr   = 1'b1;
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    rid_d    = '0;
                end else begin
                    rd_en   = 1'b1;
                    idx_d   = idx_q + IDX_W'(1);
                    beat_d  = beat_q - LEN_W'(1);
                    rlast_d = (beat_q == LEN_W'(1));
                end
            end
            default: ;
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            idx_q       <= '0;
            beat_q      <= '0;
            id_q        <= '0;
            lat_q       <= '0;
            wready_q    <= 1'b0;
            wlast_q     <= 1'b0;
            wid_q       <= '0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rid_q       <= '0;
        end else begin
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            idx_q       <= idx_d;
            beat_q      <= beat_d;
            id_q        <= id_d;
            lat_q       <= lat_d;
            wready_q    <= wready_d;
            wlast_q     <= wlast_d;
            wid_q       <= wid_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rid_q       <= rid_d;
        end
    end

    // Registered RAM read port, forced to zero between bursts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     rdata_q <= '0;
        else if (rd_en)  rdata_q <= mem[idx_q];
        else if (rd_clr) rdata_q <= '0;
    end

    // Byte-enabled RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wready_q) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (axi_wstrb[i]) mem[idx_q][8*i +: 8] <= axi_wdata[8*i +: 8];
            end
        end
    end

    assign ddr_init_done   = init_done_q;
    assign axi_wready      = wready_q;
    assign axi_wusero_id   = wid_q;
    assign axi_wusero_last = wlast_q;
    assign axi_rvalid      = rvalid_q;
    assign axi_rlast       = rlast_q;
    assign axi_rid         = rid_q;
    assign axi_rdata       = rdata_q;

endmodule
